// File: rtl/hamwt_locator.sv
// Packet Hamming-weight counter that also records the bit positions of the first
// MAX_ONES ones of each packet. Results are published one cycle after the last beat.
module hamwt_locator #(
  parameter int DATA_W    = 8,
  parameter int PKT_BEATS = 128,
  parameter int MAX_ONES  = 31,
  localparam int IDX_W    = $clog2(DATA_W * PKT_BEATS),
  localparam int WT_W     = $clog2(DATA_W * PKT_BEATS + 1)
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic                      pkt_starts,
  input  logic                      data_valid,
  input  logic [DATA_W-1:0]         bin_data,
  output logic [WT_W-1:0]           ham_wt,
  output logic [MAX_ONES*IDX_W-1:0] locn_ones,
  output logic                      loc_ovf,
  output logic                      done,
  output logic                      busy
);

  localparam int BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int LOC_W  = MAX_ONES * IDX_W;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t            state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [WT_W-1:0]   wt_q, wt_d;
  logic [LOC_W-1:0]  locs_q, locs_d;
  logic [WT_W-1:0]   ham_wt_q;
  logic [LOC_W-1:0]  locn_q;
  logic              ovf_q, done_q;

  logic              start, accept, last_beat;
  logic [BEAT_W-1:0] base_beat;
  logic [WT_W-1:0]   base_wt;
  logic [LOC_W-1:0]  base_locs;

  // A qualified start restarts the working registers, so this beat is folded into a fresh packet.
  assign start     = pkt_starts & data_valid;
  assign accept    = data_valid & (start | (state_q == ACCUM));
  assign base_beat = start ? '0 : beat_q;
  assign base_wt   = start ? '0 : wt_q;
  assign base_locs = start ? '0 : locs_q;
  assign last_beat = (base_beat == BEAT_W'(PKT_BEATS - 1));

  // Walk the beat MSB first so ones are counted and stored in increasing position order.
  always_comb begin : proc_beat
    int unsigned cnt;
    cnt    = int'(base_wt);
    locs_d = base_locs;
    for (int b = DATA_W - 1; b >= 0; b--) begin
      if (bin_data[b]) begin
        if (cnt < MAX_ONES)
          locs_d[cnt*IDX_W +: IDX_W] = IDX_W'(int'(base_beat) * DATA_W + (DATA_W - 1 - b));
        cnt = cnt + 1;
      end
    end
    wt_d = WT_W'(cnt);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wt_q     <= '0;
      locs_q   <= '0;
      ham_wt_q <= '0;
      locn_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (last_beat) begin
          state_q  <= IDLE;
          beat_q   <= '0;
          wt_q     <= '0;
          locs_q   <= '0;
          ham_wt_q <= wt_d;
          locn_q   <= locs_d;
          ovf_q    <= (int'(wt_d) > MAX_ONES);
          done_q   <= 1'b1;
        end else begin
          state_q <= ACCUM;
          beat_q  <= base_beat + 1'b1;
          wt_q    <= wt_d;
          locs_q  <= locs_d;
        end
      end
    end
  end

  assign ham_wt    = ham_wt_q;
  assign locn_ones = locn_q;
  assign loc_ovf   = ovf_q;
  assign done      = done_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_hamwt_locator.sv
// Scoreboard bench for hamwt_locator: stimulus pushes expected results, a negedge
// monitor pops and compares them whenever done pulses.
module tb_hamwt_locator;

  localparam int DATA_W    = 8;
  localparam int PKT_BEATS = 128;
  localparam int MAX_ONES  = 31;
  localparam int IDX_W     = 10;
  localparam int WT_W      = 11;
  localparam int LW        = MAX_ONES * IDX_W;

  logic              clk;
  logic              clearN;
  logic              pktStarts;
  logic              dataValid;
  logic [DATA_W-1:0] binData;
  logic [WT_W-1:0]   hamWt;
  logic [LW-1:0]     locnOnes;
  logic              locOvf;
  logic              done;
  logic              busy;

  hamwt_locator #(
    .DATA_W   (DATA_W),
    .PKT_BEATS(PKT_BEATS),
    .MAX_ONES (MAX_ONES)
  ) dut (
    .clk       (clk),
    .clear_n   (clearN),
    .pkt_starts(pktStarts),
    .data_valid(dataValid),
    .bin_data  (binData),
    .ham_wt    (hamWt),
    .locn_ones (locnOnes),
    .loc_ovf   (locOvf),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WT_W-1:0] wt;
    logic [LW-1:0]   locs;
    logic            ovf;
    int              doneCyc;
  } exp_t;

  exp_t              sbq[$];
  exp_t              monExp;
  exp_t              e;
  logic [DATA_W-1:0] pkt [PKT_BEATS];
  int                checks = 0;
  int                passes = 0;

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Slot k holds k*stride+off for k < n; remaining slots zero.
  function automatic logic [LW-1:0] slotsSeq(input int n, input int stride, input int off);
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*IDX_W +: IDX_W] = IDX_W'(k * stride + off);
    return v;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        monExp = sbq.pop_front();
        checkOutput("ham_wt", LW'(hamWt), LW'(monExp.wt));
        checkOutput("locn_ones", locnOnes, monExp.locs);
        checkOutput("loc_ovf", LW'(locOvf), LW'(monExp.ovf));
        checkOutput("done_cycle", LW'(cyc), LW'(monExp.doneCyc));
      end
    end
  end

  // One valid beat, preceded by up to gapMax idle cycles carrying junk that must be ignored.
  task automatic applyStimulus(input logic st, input logic [DATA_W-1:0] d, input int gapMax);
    int gap;
    gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
    repeat (gap) begin
      dataValid = 1'b0;
      pktStarts = 1'($urandom_range(0, 1));
      binData   = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    pktStarts = st;
    dataValid = 1'b1;
    binData   = d;
    @(posedge clk); #1;
    dataValid = 1'b0;
    pktStarts = 1'b0;
  endtask

  task automatic runPacket(input int gapMax, input exp_t ex);
    for (int i = 0; i < PKT_BEATS; i++) applyStimulus(i == 0, pkt[i], gapMax);
    ex.doneCyc = cyc;
    sbq.push_back(ex);
  endtask

  task automatic fillPkt(input logic [DATA_W-1:0] v);
    for (int i = 0; i < PKT_BEATS; i++) pkt[i] = v;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sbq.size() == 0) passes++;
    else $display("[TB] FAIL %s_drain: got %0d pending results expected 0", name, sbq.size());
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearN    = 1'b0;
    pktStarts = 1'b0;
    dataValid = 1'b0;
    binData   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ham_wt", LW'(hamWt), '0);
    checkOutput("reset_locn", locnOnes, '0);
    checkOutput("reset_ovf", LW'(locOvf), '0);
    checkOutput("reset_done", LW'(done), '0);
    checkOutput("reset_busy", LW'(busy), '0);
    clearN = 1'b1;
    @(posedge clk); #1;

    // All-zero packet
    fillPkt(8'h00);
    e = '{wt: 11'd0, locs: '0, ovf: 1'b0, doneCyc: 0};
    runPacket(0, e);
    waitDrain("zeros");
    checkOutput("idle_busy", LW'(busy), '0);

    // First and last bit positions
    fillPkt(8'h00);
    pkt[0] = 8'h81;
    pkt[PKT_BEATS-1] = 8'h01;
    e.wt = 11'd3; e.ovf = 1'b0; e.locs = '0;
    e.locs[0*IDX_W +: IDX_W] = 10'd0;
    e.locs[1*IDX_W +: IDX_W] = 10'd7;
    e.locs[2*IDX_W +: IDX_W] = 10'd1023;
    runPacket(0, e);
    waitDrain("ends");
    checkOutput("hold_ham_wt", LW'(hamWt), LW'(11'd3));

    // Every bit set: weight saturates nothing, slots overflow
    fillPkt(8'hFF);
    e.wt = 11'd1024; e.ovf = 1'b1; e.locs = slotsSeq(31, 1, 0);
    runPacket(0, e);
    waitDrain("ones");

    // Mixed pattern with a few scattered ones
    fillPkt(8'h00);
    pkt[2]  = 8'hA0;
    pkt[10] = 8'h03;
    e.wt = 11'd4; e.ovf = 1'b0; e.locs = '0;
    e.locs[0*IDX_W +: IDX_W] = 10'd16;
    e.locs[1*IDX_W +: IDX_W] = 10'd18;
    e.locs[2*IDX_W +: IDX_W] = 10'd86;
    e.locs[3*IDX_W +: IDX_W] = 10'd87;
    runPacket(0, e);
    waitDrain("mixed");

    // Gapped valid beats with junk pkt_starts during gaps
    fillPkt(8'h00);
    pkt[5] = 8'h40;
    e.wt = 11'd1; e.ovf = 1'b0; e.locs = '0;
    e.locs[0*IDX_W +: IDX_W] = 10'd41;
    runPacket(3, e);
    waitDrain("gaps");

    // Restart mid-packet at beat 60
    for (int i = 0; i < 60; i++) applyStimulus(i == 0, 8'hFF, 0);
    checkOutput("accum_busy", LW'(busy), LW'(1'b1));
    fillPkt(8'h00);
    pkt[0] = 8'h80;
    e.wt = 11'd1; e.ovf = 1'b0; e.locs = '0;
    runPacket(0, e);
    waitDrain("restart60");

    // Restart coinciding with what would have been the final beat
    for (int i = 0; i < PKT_BEATS - 1; i++) applyStimulus(i == 0, 8'hFF, 0);
    runPacket(0, e);
    waitDrain("restart_last");

    // Reset aborts a half-finished packet and clears the results
    for (int i = 0; i < 64; i++) applyStimulus(i == 0, 8'hFF, 0);
    clearN = 1'b0;
    pktStarts = 1'b1;
    dataValid = 1'b1;
    @(posedge clk); #1;
    clearN = 1'b1;
    pktStarts = 1'b0;
    dataValid = 1'b0;
    checkOutput("abort_ham_wt", LW'(hamWt), '0);
    checkOutput("abort_busy", LW'(busy), '0);
    fillPkt(8'h01);
    e.wt = 11'd128; e.ovf = 1'b1; e.locs = slotsSeq(31, 8, 7);
    runPacket(0, e);
    waitDrain("after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hamwt_locator.md
HAMWT_LOCATOR -- requirements
Module: hamwt_locator

Interface
REQ-001 Parameter DATA_W, default 8: bits per input beat.
REQ-002 Parameter PKT_BEATS, default 128: valid beats per packet; DATA_W*PKT_BEATS = 1024-bit packet.
REQ-003 Parameter MAX_ONES, default 31: number of one-locations recorded per packet.
REQ-004 Derived: IDX_W = clog2(DATA_W*PKT_BEATS) = 10; WT_W = clog2(DATA_W*PKT_BEATS+1) = 11.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 clear_n  input  1  reset, synchronous, active-low.
REQ-007 pkt_starts  input  1  high on first beat of a packet.
REQ-008 data_valid  input  1  bin_data is a valid beat this cycle.
REQ-009 bin_data  input  DATA_W  packet data, MSB first.
REQ-010 ham_wt  output  WT_W  total ones in last completed packet, unsaturated.
REQ-011 locn_ones  output  MAX_ONES*IDX_W  packed bit positions of the first MAX_ONES ones.
REQ-012 loc_ovf  output  1  last packet had more than MAX_ONES ones.
REQ-013 done  output  1  one-cycle pulse: result outputs just updated.
REQ-014 busy  output  1  packet accumulation in progress.

Function
REQ-015 States IDLE, ACCUM: IDLE->ACCUM on pkt_starts&data_valid; ACCUM->IDLE after the PKT_BEATS-th valid beat.
REQ-016 pkt_starts without data_valid is ignored in every state.
REQ-017 Bit position of bin_data[b] in beat n (n from 0) = n*DATA_W + (DATA_W-1-b); packet bit 0 = MSB of first beat.
REQ-018 Beat counter counts valid beats only; data_valid low stalls without changing internal state.
REQ-019 Every set bit of a valid beat adds 1 to the working weight; all DATA_W bits processed in the same cycle.
REQ-020 Locations stored in order of increasing position: k-th one (k from 0) in locn_ones[k*IDX_W +: IDX_W].
REQ-021 Ones beyond the MAX_ONES-th still count toward weight; they are not stored; loc_ovf sets.
REQ-022 Slots with no recorded one read 0.
REQ-023 Working registers clear at the start of each packet; the first beat's bits are included.
REQ-024 Last valid beat at cycle t: ham_wt, locn_ones, loc_ovf update and done=1 at cycle t+1; latency 1 cycle.
REQ-025 Outputs hold between done pulses; working state is never visible on outputs.
REQ-026 pkt_starts&data_valid while in ACCUM: current packet discarded, no done, new packet starts with this beat.
REQ-027 If the final beat of one packet and pkt_starts of the next would coincide, REQ-026 takes priority (restart).
REQ-028 busy=1 in ACCUM, 0 in IDLE.
REQ-029 Weight arithmetic is WT_W wide and cannot wrap: max 1024 fits in 11 bits.

Reset
REQ-030 clear_n=0 at a clock edge: state IDLE; beat counter, working weight and slots cleared; ham_wt=0, locn_ones=0, loc_ovf=0, done=0, busy=0.
REQ-031 Reset during ACCUM aborts the packet with no done; reset has priority over all other inputs.

Verification
REQ-032 Packet of 128 beats, all 0x00 -> done once, ham_wt=0, locn_ones=0, loc_ovf=0.
REQ-033 Beat0=0x81, beat127=0x01, rest 0x00 -> ham_wt=3, slot0=0, slot1=7, slot2=1023, other slots 0, loc_ovf=0.
REQ-034 All beats 0xFF -> ham_wt=1024, slots k=0..30 hold k, loc_ovf=1.
REQ-035 Valid beats interleaved with data_valid=0 cycles (random gaps), beat5=0x40 -> ham_wt=1, slot0=41; done one cycle after 128th valid beat.
REQ-036 pkt_starts at beat 60 of a packet, then 128 beats with beat0=0x80 -> exactly one done, ham_wt=1, slot0=0.
REQ-037 clear_n low at beat 64, then full packet of 0x01 -> no done for aborted packet; ham_wt=128, loc_ovf=1, slot0=7.
